// File: rtl/kogge_stone_adder_pipe.sv
// kogge_stone_adder_pipe: fully pipelined Kogge-Stone adder/subtractor with
// valid/ready handshakes on both sides and one prefix level per stage.
// Stage 0 registers generate/propagate.
// Stages 1..K each apply one prefix level.
// A final registered stage forms sum, cout and overflow.
// Optional feature macro: KSA_SAT_EN builds the signed saturation mux in the
// final stage. Without it, the sat input is ignored.
// The carry-in is folded into the prefix tree as bit -1, held at vector
// index 0. Operand bit i therefore lives at index i+1 of the G/P vectors.
module kogge_stone_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int K = $clog2(WIDTH);
    localparam int N = WIDTH + 1;

    // Black cell: combine a high group {g,p} with the adjacent lower group.
    function automatic logic [1:0] ks_black(
        input logic g_hi,
        input logic p_hi,
        input logic g_lo,
        input logic p_lo
    );
        ks_black = {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    logic                      w_advance;
    logic [WIDTH-1:0]          w_b_eff;
    logic [WIDTH-1:0]          w_praw_in;
    logic [N-1:0]              w_g_in;
    logic [N-1:0]              w_p_in;
    logic [K:1][N-1:0]         w_g_nxt;
    logic [K:1][N-1:0]         w_p_nxt;
    logic [WIDTH-1:0]          w_raw_sum;
    logic [WIDTH-1:0]          w_sum_fin;
    logic                      w_cout;
    logic                      w_ovf;

    logic [K:0]                r_valid;
    logic [K:0][N-1:0]         r_g;
    logic [K:0][N-1:0]         r_p;
    logic [K:0][WIDTH-1:0]     r_praw;
    logic [K:0]                r_a_msb;
    logic [K:0]                r_b_msb;
    logic                      r_out_valid;
    logic [WIDTH-1:0]          r_sum;
    logic                      r_cout;
    logic                      r_ovf;

    // Single global stall: the whole pipe moves only when the output slot frees.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

    // Input preprocessing: invert b for subtract and fold the carry-in in as bit -1.
    always_comb begin
        w_b_eff   = sub ? ~operand_b : operand_b;
        w_praw_in = operand_a ^ w_b_eff;
        w_g_in    = {operand_a & w_b_eff, cin ^ sub};
        w_p_in    = {w_praw_in, 1'b0};
    end

    // Prefix levels: level j combines each index with the one 2^(j-1) below it.
    always_comb begin
        w_g_nxt = '0;
        w_p_nxt = '0;
        for (int j = 1; j <= K; j++) begin
            w_g_nxt[j] = r_g[j-1];
            w_p_nxt[j] = r_p[j-1];
            for (int x = (1 << (j - 1)); x < N; x++) begin
                {w_g_nxt[j][x], w_p_nxt[j][x]} = ks_black(r_g[j-1][x], r_p[j-1][x],
                                                         r_g[j-1][x - (1 << (j - 1))],
                                                         r_p[j-1][x - (1 << (j - 1))]);
            end
        end
    end

`ifdef KSA_SAT_EN
    logic [K:0] r_sat;

    // Carry each beat's saturation request alongside its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= '0;
        end else if (w_advance) begin
            r_sat <= {r_sat[K-1:0], sat};
        end
    end
`else
    logic w_unused_sat;
    assign w_unused_sat = sat;
`endif

    // Final stage: carries are complete up to bit WIDTH-1. The top index may
    // still need the bit -1 group when WIDTH is a power of two.
    always_comb begin
        w_raw_sum = r_praw[K] ^ r_g[K][WIDTH-1:0];
        w_cout    = r_g[K][WIDTH] | (r_p[K][WIDTH] & r_g[K][0]);
        w_ovf     = (r_a_msb[K] == r_b_msb[K]) && (w_raw_sum[WIDTH-1] != r_a_msb[K]);
        w_sum_fin = w_raw_sum;
`ifdef KSA_SAT_EN
        if (r_sat[K] && w_ovf) begin
            if (r_a_msb[K]) begin
                w_sum_fin = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                w_sum_fin = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            w_sum_fin = w_raw_sum;
        end
`endif
    end

    // Pipeline registers: shift every stage together, or hold everything on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_g         <= '0;
            r_p         <= '0;
            r_praw      <= '0;
            r_a_msb     <= '0;
            r_b_msb     <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_valid     <= {r_valid[K-1:0], in_valid};
            r_g         <= {w_g_nxt, w_g_in};
            r_p         <= {w_p_nxt, w_p_in};
            r_praw      <= {r_praw[K-1:0], w_praw_in};
            r_a_msb     <= {r_a_msb[K-1:0], operand_a[WIDTH-1]};
            r_b_msb     <= {r_b_msb[K-1:0], w_b_eff[WIDTH-1]};
            r_out_valid <= r_valid[K];
            if (r_valid[K]) begin
                r_sum  <= w_sum_fin;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_kogge_stone_adder_pipe.sv
// tb_kogge_stone_adder_pipe: self-checking bench for the pipelined
// Kogge-Stone adder at WIDTH=8. Expected results come from a plain integer
// model and flow through a scoreboard queue. Honours KSA_SAT_EN.
module tb_kogge_stone_adder_pipe;

    localparam int WIDTH = 8;
    localparam int LAT   = 5;
`ifdef KSA_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             cin;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    kogge_stone_adder_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow)
    );

    // Reference: returns {overflow, cout, sum}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb, input logic st);
        logic [7:0] be;
        logic [8:0] full;
        logic [7:0] s;
        logic       ov;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {8'd0, ci ^ sb};
        s    = full[7:0];
        ov   = (a[7] == be[7]) && (s[7] != a[7]);
        if (SAT_EN && st && ov) s = a[7] ? 8'h80 : 8'h7F;
        return {ov, full[8], s};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand_a = 8'h00; operand_b = 8'h00; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, expected 0/00/0/0",
                     out_valid, sum, cout, overflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta [0:5];
        logic [7:0] tb [0:5];
        logic [4:0] tf [0:5];  // {cin, sub, sat}
        logic [9:0] ex;
        int lat;
        bit got;
        ta = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00, 8'h00};
        tb = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h00, 8'h00};
        tf = '{5'b000, 5'b001, 5'b010, 5'b011, 5'b100, 5'b110};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            operand_a = ta[i]; operand_b = tb[i];
            {cin, sub, sat} = tf[i][2:0];
            exp_q.push_back(model(ta[i], tb[i], tf[i][2], tf[i][1], tf[i][0]));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0; got = 1'b0;
            while (lat < 12 && !got) begin
                @(negedge clk);
                lat++;
                if (out_valid === 1'b1) got = 1'b1;
            end
            checks++;
            if (lat != LAT || !got) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles expected %0d", i, lat, LAT);
            end
            ex = exp_q.pop_front();
            checks++;
            if (sum !== ex[7:0]) begin
                errors++;
                $display("FAIL directed_sum[%0d]: got %h expected %h", i, sum, ex[7:0]);
            end
            checks++;
            if (cout !== ex[8]) begin
                errors++;
                $display("FAIL directed_cout[%0d]: got %b expected %b", i, cout, ex[8]);
            end
            checks++;
            if (overflow !== ex[9]) begin
                errors++;
                $display("FAIL directed_overflow[%0d]: got %b expected %b", i, overflow, ex[9]);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_stream(input int n, input bit rand_ready);
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        logic [7:0] a_p, b_p;
        logic ci_p, sb_p, st_p;
        logic stall_prev = 1'b0;
        logic [7:0] s_hold;
        logic c_hold, o_hold;
        logic [9:0] ex;
        a_p = 8'($urandom_range(0, 255)); b_p = 8'($urandom_range(0, 255));
        ci_p = 1'($urandom_range(0, 1)); sb_p = 1'($urandom_range(0, 1));
        st_p = 1'($urandom_range(0, 1));
        @(negedge clk);
        while ((sent < n || rcvd < n) && cyc < 2000) begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== s_hold || cout !== c_hold || overflow !== o_hold) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h/%b/%b expected 1 %h/%b/%b",
                             out_valid, sum, cout, overflow, s_hold, c_hold, o_hold);
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < n);
            operand_a = a_p; operand_b = b_p; cin = ci_p; sub = sb_p; sat = st_p;
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b",
                         in_ready, out_valid, out_ready);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_beat: got %h with empty scoreboard", sum);
                end else begin
                    ex = exp_q.pop_front();
                    if ({overflow, cout, sum} !== ex) begin
                        errors++;
                        $display("FAIL stream_result[%0d]: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                                 rcvd, overflow, cout, sum, ex[9], ex[8], ex[7:0]);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(a_p, b_p, ci_p, sb_p, st_p));
                sent++;
                a_p = 8'($urandom_range(0, 255)); b_p = 8'($urandom_range(0, 255));
                ci_p = 1'($urandom_range(0, 1)); sb_p = 1'($urandom_range(0, 1));
                st_p = 1'($urandom_range(0, 1));
            end
            stall_prev = out_valid && !out_ready;
            s_hold = sum; c_hold = cout; o_hold = overflow;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d delivered (%0d pending) expected %0d", rcvd, exp_q.size(), n);
        end
        if (!rand_ready) begin
            checks++;
            if (cyc != n + LAT) begin
                errors++;
                $display("FAIL full_rate_cycles: got %0d expected %0d", cyc, n + LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_stream(12, 1'b0);
    endtask

    task automatic test_random_stall();
        test_stream(20, 1'b1);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit got;
        @(negedge clk);
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            operand_a = (i == 0) ? 8'hF0 : 8'h33;
            operand_b = 8'h20;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 12 && !got) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || sum !== 8'h10 || cout !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_beat: got v=%b sum=%h cout=%b expected 1 10 1", out_valid, sum, cout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b sum=%h cout=%b ovf=%b expected 0/00/0/0",
                     out_valid, sum, cout, overflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat[%0d]: got out_valid=%b sum=%h expected 0", i, out_valid, sum);
            end
        end
        in_valid = 1'b1; operand_a = 8'h10; operand_b = 8'h20;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 12 && !got) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || lat != LAT) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d cycles expected %0d", lat, LAT);
        end
        checks++;
        if (sum !== 8'h30 || {overflow, cout, sum} !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL post_reset_sum: got %h cout=%b ovf=%b expected 30 0 0", sum, cout, overflow);
        end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
